md_sched: RTL
=============

// Module: md_sched
// PURPOSE
//  Sequences the multiply/divide unit and owns the HI/LO registers for the 5-stage MIPS core.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E stage and models multi-cycle latency with a busy counter.
//  Drives the HI/LO-hazard stall for the D-stage instruction and serves MFHI/MFLO reads.
//  Sits beside the ALU in E; the stall controller ORs stall_md into its freeze signal.
// PARAMETERS
//  MUL_LAT  5   cycles busy after MULT/MULTU start (1..15)
//  DIV_LAT  10  cycles busy after DIV/DIVU start (1..15)
// PORTS
//  clk        in   1   core clock
//  reset      in   1   asynchronous, active-low; clears all state
//  md_op      in   4   E-stage op code (MD_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO)
//  rs_val     in   32  forwarded rs operand (E stage)
//  rt_val     in   32  forwarded rt operand (E stage)
//  flush      in   1   exception/eret this cycle: the E-stage op is killed
//  d_use_md   in   1   D-stage instr is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
//  stall_md   out  1   freeze D (comb.)
//  busy       out  1   registered; unit is running
//  md_rdata   out  32  HI when md_op==MFHI, LO when MFLO, else 0 (comb.)
//  hi, lo     out  32  architectural HI/LO (registered)
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending results=0. Reset mid-operation drops the op.
//  - start_fire = (md_op is MULT/MULTU/DIV/DIVU) & ~flush & ~busy, in cycle T.
//  - FSM IDLE->MUL_RUN (mult start) or DIV_RUN (div start) at edge ending T. cnt loads MUL_LAT or DIV_LAT.
//    The result is latched into pend_hi/pend_lo at the same edge.
//  - In RUN, cnt decrements each cycle. busy=1 in cycles T+1..T+LAT.
//    At the edge with cnt==1: hi<=pend_hi, lo<=pend_lo, state->IDLE. busy=0 from T+LAT+1.
//  - New HI/LO are visible at T+LAT+1. No back-to-back start: the D stall makes busy & start impossible.
//    A start while busy is ignored (assertion).
//  - stall_md = d_use_md & (start_fire | busy).
//  - MTHI/MTLO (~flush, ~busy): hi/lo <= rs_val at the edge ending T; no busy. Ignored if busy (assertion).
//  - flush kills only the E-stage op: no start, no mt write. An already-running op completes and commits normally.
//  - MULT: signed 32x32->64, {HI,LO}=product. MULTU: unsigned.
//  - DIV: signed, quotient truncated toward zero, LO=quot, HI=rem (rem takes the dividend's sign).
//    0x80000000/-1 -> LO=0x80000000, HI=0.
//  - DIVU: unsigned.
//  - Divide by zero: the unit runs the full DIV_LAT busy period and pend = current hi/lo, so HI/LO are unchanged.
//  - md_rdata reads the committed hi/lo. MFHI/MFLO never reaches E while busy (stalled in D).
// STRUCTURE
//  - const.v (shared header): MD_* op encodings, and funct defines for mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
//    The D-stage decoder uses the same defines to build d_use_md.
//  - Sub-module md_arith: combinational; md_op, rs_val, rt_val, hi, lo -> res_hi, res_lo.
//    Includes signed/unsigned mul/div and the div-by-zero hold.
//  - md_sched: FSM, 4-bit counter, pend and HI/LO registers, stall logic.
// TESTING
//  1 MULT rs=0xFFFFFFFF rt=2 at T -> busy T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFE at T+6.
//  2 MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE at T+6.
//    DIVU 7/2 -> lo=3, hi=1 at T+11.
//  3 DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+11.
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4 DIV x/0 with hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
//  5 MULT at T, d_use_md=1 (MFHI) T..T+6 -> stall_md=1 T..T+5, 0 at T+6.
//    MFHI then reads md_rdata=new hi.
//  6 DIV with flush=1 at T -> busy stays 0, hi/lo unchanged.
//    reset low at T+4 of a DIV -> busy=0, hi=lo=0 immediately (async).
//    MTLO rs=0xABCD -> lo=0xABCD next cycle.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared op encodings and FSM states for the multiply/divide scheduler.
// The D-stage decoder uses the same encodings to build d_use_md.
package md_sched_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2
  } md_state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the {HI,LO} result.
// Divide by zero returns the current HI/LO so a commit leaves them unchanged.
module md_arith
  import md_sched_pkg::*;
(
  input  logic [3:0]  md_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_u = {32'd0, rs_i} * {32'd0, rt_i};
    prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};

    // Magnitude divide avoids the INT_MIN / -1 overflow case; it wraps to 0x80000000.
    a_neg   = (md_op_i == MD_DIV) && rs_i[31];
    b_neg   = (md_op_i == MD_DIV) && rt_i[31];
    a_mag   = a_neg ? (~rs_i + 32'd1) : rs_i;
    b_mag   = b_neg ? (~rt_i + 32'd1) : rt_i;
    divisor = (rt_i == '0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_hi_o = hi_i;
    res_lo_o = lo_i;
    case (md_op_i)
      MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
      MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (rt_i != '0) begin
          res_hi_o = rem;
          res_lo_o = quot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, models latency with a busy counter,
// and raises the D-stage HI/LO hazard stall.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_use_md,
  output logic        stall_md,
  output logic        busy,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi, res_lo;
  logic        start_req, mt_req, start_fire, mt_fire;

  md_arith u_arith (
    .md_op_i  (md_op),
    .rs_i     (rs_val),
    .rt_i     (rt_val),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  assign busy       = (state_q != S_IDLE);
  assign start_req  = is_mul(md_op) || is_div(md_op);
  assign mt_req     = (md_op == MD_MTHI) || (md_op == MD_MTLO);
  assign start_fire = start_req && !flush && !busy;
  assign mt_fire    = mt_req && !flush && !busy;
  assign stall_md   = d_use_md && (start_fire || busy);
  assign hi         = hi_q;
  assign lo         = lo_q;

  always_comb begin
    case (md_op)
      MD_MFHI: md_rdata = hi_q;
      MD_MFLO: md_rdata = lo_q;
      default: md_rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_fire) begin
          state_d   = is_mul(md_op) ? S_MUL_RUN : S_DIV_RUN;
          cnt_d     = is_mul(md_op) ? MUL_CNT : DIV_CNT;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
        end else if (mt_fire) begin
          if (md_op == MD_MTHI) hi_d = rs_val;
          else                  lo_d = rs_val;
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

`ifndef SYNTHESIS
  a_no_op_while_busy: assert property (@(posedge clk) disable iff (!reset)
    !(busy && (start_req || mt_req) && !flush));
`endif

endmodule
